// File: rtl/input_checker_if.sv
// ---------------------------------------------------------------------------
// input_checker_if
//
// Groups the signals exchanged between input_checker and its surroundings:
// the game fsm, the player buttons, the LED-code memory and the top level.
//
//   check_en  fsm -> checker     high while the player enters the sequence
//   level     fsm -> checker     sequence length minus one (valid 0..9)
//   btn       buttons -> checker active-high, already synchronised to clk
//   expected  memory -> checker  LED code stored at addr (asynchronous read)
//   addr      checker -> memory  index of the press being checked
//   pass      checker -> fsm     whole sequence entered correctly
//   fail      checker -> fsm     wrong button or timeout
//   led_echo  checker -> top     one-hot echo of the accepted button
//
// master: the environment side (fsm, buttons, memory).
// slave : the checker itself.
// ---------------------------------------------------------------------------
interface input_checker_if;
   logic       check_en;
   logic [3:0] level;
   logic [3:0] btn;
   logic [1:0] expected;
   logic [3:0] addr;
   logic       pass;
   logic       fail;
   logic [9:0] led_echo;

   modport master (
      output check_en, level, btn, expected,
      input  addr, pass, fail, led_echo
   );

   modport slave (
      input  check_en, level, btn, expected,
      output addr, pass, fail, led_echo
   );
endinterface

// File: rtl/input_checker.sv
// ---------------------------------------------------------------------------
// input_checker
//
// Checks the button sequence entered by the player against the LED codes held
// in an external memory. Each press must be a single button, stable for
// DEBOUNCE_CYCLES cycles, and must arrive within TIMEOUT_CYCLES cycles of the
// previous accepted press (or of the start of entry). The accepted button is
// echoed on led_echo until it is released.
//
// Ports:
//   clk    system clock, all state changes on its rising edge
//   reset  synchronous, active-high reset
//   bus    input_checker_if.slave (check_en, level, btn, expected in;
//          addr, pass, fail, led_echo out)
//
// Parameters:
//   DEBOUNCE_CYCLES  cycles a one-hot pattern must be stable to count
//   TIMEOUT_CYCLES   maximum cycles allowed between accepted presses
// ---------------------------------------------------------------------------
module input_checker #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int TIMEOUT_CYCLES  = 250_000_000
) (
   input  logic           clk,
   input  logic           reset,
   input_checker_if.slave bus
);

   // The cycle in which WAIT_PRESS first sees the pattern counts as the first
   // stable cycle, so DEBOUNCE finishes after DEBOUNCE_CYCLES-1 further
   // stable cycles, i.e. when the counter (cleared on entry) reaches
   // DEBOUNCE_CYCLES-2.
   localparam int DEB_LAST_INT = (DEBOUNCE_CYCLES >= 2) ? DEBOUNCE_CYCLES - 2 : 0;
   localparam int TMO_LAST_INT = (TIMEOUT_CYCLES >= 1) ? TIMEOUT_CYCLES - 1 : 0;
   localparam int DEB_W        = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int TMO_W        = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_LAST_INT);
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_LAST_INT);

   localparam logic [2:0] S_IDLE         = 3'd0;
   localparam logic [2:0] S_WAIT_PRESS   = 3'd1;
   localparam logic [2:0] S_DEBOUNCE     = 3'd2;
   localparam logic [2:0] S_WAIT_RELEASE = 3'd3;
   localparam logic [2:0] S_PASS         = 3'd4;
   localparam logic [2:0] S_FAIL         = 3'd5;

   logic [2:0]       state_reg,   state_next;
   logic [3:0]       addr_reg,    addr_next;
   logic [3:0]       pattern_reg, pattern_next;
   logic [DEB_W-1:0] deb_cnt_reg, deb_cnt_next;
   logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
   logic [TMO_W-1:0] tmo_cnt_inc;
   logic             btn_valid;
   logic [1:0]       pattern_code;

   function automatic logic is_onehot(input logic [3:0] b);
      case (b)
         4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
         default:                            return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] encode(input logic [3:0] b);
      case (b)
         4'b0010: return 2'd1;
         4'b0100: return 2'd2;
         4'b1000: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   assign btn_valid    = is_onehot(bus.btn);
   assign pattern_code = encode(pattern_reg);

   // Timeout counter sticks at its last value instead of wrapping; once it
   // is there, the next cycle spent in WAIT_PRESS times out.
   assign tmo_cnt_inc = (tmo_cnt_reg == TMO_LAST) ? tmo_cnt_reg
                                                  : tmo_cnt_reg + TMO_W'(1);

   always_comb begin
      state_next   = state_reg;
      addr_next    = addr_reg;
      pattern_next = pattern_reg;
      deb_cnt_next = deb_cnt_reg;
      tmo_cnt_next = tmo_cnt_reg;

      if (!bus.check_en) begin
         // Dropping check_en aborts everything, whatever else happens.
         state_next   = S_IDLE;
         addr_next    = '0;
         pattern_next = '0;
         deb_cnt_next = '0;
         tmo_cnt_next = '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (bus.level <= 4'd9) begin
                  state_next   = S_WAIT_PRESS;
                  addr_next    = '0;
                  tmo_cnt_next = '0;
               end
            end

            S_WAIT_PRESS: begin
               // Timeout wins over a press arriving in the same cycle.
               if (tmo_cnt_reg == TMO_LAST) begin
                  state_next = S_FAIL;
               end else begin
                  tmo_cnt_next = tmo_cnt_inc;
                  if (btn_valid) begin
                     pattern_next = bus.btn;
                     deb_cnt_next = '0;
                     state_next   = S_DEBOUNCE;
                  end
               end
            end

            S_DEBOUNCE: begin
               tmo_cnt_next = tmo_cnt_inc;
               if (bus.btn != pattern_reg) begin
                  state_next = S_WAIT_PRESS;
               end else if (deb_cnt_reg == DEB_LAST) begin
                  if (pattern_code == bus.expected) begin
                     state_next   = S_WAIT_RELEASE;
                     tmo_cnt_next = '0;
                  end else begin
                     state_next = S_FAIL;
                  end
               end else begin
                  deb_cnt_next = deb_cnt_reg + DEB_W'(1);
               end
            end

            S_WAIT_RELEASE: begin
               if (bus.btn == 4'd0) begin
                  if (addr_reg == bus.level) begin
                     state_next = S_PASS;
                  end else begin
                     addr_next  = addr_reg + 4'd1;
                     state_next = S_WAIT_PRESS;
                  end
               end
            end

            S_PASS, S_FAIL: begin
               state_next = state_reg;
            end

            default: begin
               state_next   = S_IDLE;
               addr_next    = '0;
               pattern_next = '0;
               deb_cnt_next = '0;
               tmo_cnt_next = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= S_IDLE;
         addr_reg    <= '0;
         pattern_reg <= '0;
         deb_cnt_reg <= '0;
         tmo_cnt_reg <= '0;
      end else begin
         state_reg   <= state_next;
         addr_reg    <= addr_next;
         pattern_reg <= pattern_next;
         deb_cnt_reg <= deb_cnt_next;
         tmo_cnt_reg <= tmo_cnt_next;
      end
   end

   // Outputs are decoded from registered state, so pass and fail are
   // mutually exclusive by construction.
   assign bus.addr     = addr_reg;
   assign bus.pass     = (state_reg == S_PASS);
   assign bus.fail     = (state_reg == S_FAIL);
   assign bus.led_echo = (state_reg == S_WAIT_RELEASE) ? {6'd0, pattern_reg} : 10'd0;

endmodule

// File: tb/tb_input_checker.sv
// ---------------------------------------------------------------------------
// tb_input_checker
//
// Self-checking bench for input_checker with DEBOUNCE_CYCLES=4 and
// TIMEOUT_CYCLES=50. Inputs change 1 time unit after a rising edge and
// outputs are sampled at that same point, away from the active edge.
// Expected behaviour is stated in terms of presses and cycle counts: a press
// is accepted once seen on DEB consecutive edges, the attempt times out after
// TMO cycles spent waiting without an accepted press.
// ---------------------------------------------------------------------------
module tb_input_checker;
   localparam int DEB = 4;
   localparam int TMO = 50;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] mem [16];
   int         n_checks = 0;
   int         n_fail   = 0;

   always #5 clk = ~clk;

   input_checker_if bus ();

   // Behavioural asynchronous-read LED-code memory.
   assign bus.expected = mem[bus.addr];

   input_checker #(
      .DEBOUNCE_CYCLES (DEB),
      .TIMEOUT_CYCLES  (TMO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic begin_check(input logic [3:0] lvl);
      bus.level    = lvl;
      bus.btn      = 4'd0;
      bus.check_en = 1'b1;
      step(1);
   endtask

   task automatic end_check();
      bus.check_en = 1'b0;
      bus.btn      = 4'd0;
      step(1);
   endtask

   function automatic logic [3:0] onehot(input logic [1:0] c);
      logic [3:0] one;
      one = 4'b0001;
      return one << c;
   endfunction

   task automatic test_reset();
      reset        = 1'b1;
      bus.check_en = 1'b0;
      bus.level    = 4'd0;
      bus.btn      = 4'd0;
      step(2);
      n_checks++;
      if ({bus.addr, bus.pass, bus.fail, bus.led_echo} !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_initial: got addr=%0d pass=%b fail=%b led=%h, want all 0",
                  bus.addr, bus.pass, bus.fail, bus.led_echo);
      end
      reset = 1'b0;
      step(1);

      mem[0] = 2'd1;
      mem[1] = 2'd2;
      begin_check(4'd1);
      bus.btn = 4'b0010;
      step(DEB);
      n_checks++;
      if (bus.led_echo !== 10'h002) begin
         n_fail++;
         $display("FAIL reset_pre_echo: got led=%h want 002", bus.led_echo);
      end
      bus.btn = 4'd0;
      step(1);
      n_checks++;
      if (bus.addr !== 4'd1) begin
         n_fail++;
         $display("FAIL reset_pre_addr: got addr=%0d want 1", bus.addr);
      end

      // Reset mid-sequence with check_en still high.
      reset = 1'b1;
      step(1);
      n_checks++;
      if ({bus.addr, bus.pass, bus.fail, bus.led_echo} !== 16'd0) begin
         n_fail++;
         $display("FAIL reset_mid: got addr=%0d pass=%b fail=%b led=%h, want all 0",
                  bus.addr, bus.pass, bus.fail, bus.led_echo);
      end
      reset = 1'b0;
      step(1);

      // Progress is discarded: the first press is checked against mem[0] again.
      bus.btn = 4'b0010;
      step(DEB);
      n_checks++;
      if (bus.led_echo !== 10'h002 || bus.fail !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_restart: got led=%h fail=%b want led=002 fail=0",
                  bus.led_echo, bus.fail);
      end
      bus.btn = 4'd0;
      step(1);
      n_checks++;
      if (bus.addr !== 4'd1) begin
         n_fail++;
         $display("FAIL reset_restart_addr: got addr=%0d want 1", bus.addr);
      end
      end_check();
      $display("test_reset done");
   endtask

   task automatic test_correct_sequence();
      logic [3:0] seq [3];
      seq[0] = 4'b0010;
      seq[1] = 4'b1000;
      seq[2] = 4'b0001;
      mem[0] = 2'd1;
      mem[1] = 2'd3;
      mem[2] = 2'd0;
      begin_check(4'd2);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (bus.addr !== 4'(i)) begin
            n_fail++;
            $display("FAIL seq_addr[%0d]: got addr=%0d want %0d", i, bus.addr, i);
         end
         bus.btn = seq[i];
         step(DEB);
         n_checks++;
         if (bus.led_echo !== {6'd0, seq[i]}) begin
            n_fail++;
            $display("FAIL seq_echo[%0d]: got led=%h want %h", i, bus.led_echo, {6'd0, seq[i]});
         end
         step(6 - DEB);
         bus.btn = 4'd0;
         step(1);
         n_checks++;
         if (bus.pass !== (i == 2) || bus.fail !== 1'b0 || bus.led_echo !== 10'd0) begin
            n_fail++;
            $display("FAIL seq_release[%0d]: got pass=%b fail=%b led=%h want pass=%b fail=0 led=0",
                     i, bus.pass, bus.fail, bus.led_echo, (i == 2));
         end
      end
      step(3);
      n_checks++;
      if (bus.pass !== 1'b1 || bus.fail !== 1'b0) begin
         n_fail++;
         $display("FAIL seq_pass_hold: got pass=%b fail=%b want pass=1 fail=0", bus.pass, bus.fail);
      end
      end_check();
      n_checks++;
      if (bus.pass !== 1'b0) begin
         n_fail++;
         $display("FAIL seq_pass_clear: got pass=%b want 0", bus.pass);
      end
      $display("test_correct_sequence done");
   endtask

   task automatic test_wrong_button();
      mem[0] = 2'd2;
      begin_check(4'd1);
      bus.btn = 4'b0001;
      step(DEB - 1);
      n_checks++;
      if (bus.fail !== 1'b0) begin
         n_fail++;
         $display("FAIL wrong_early: got fail=%b want 0", bus.fail);
      end
      step(1);
      n_checks++;
      if (bus.fail !== 1'b1 || bus.led_echo !== 10'd0 || bus.pass !== 1'b0) begin
         n_fail++;
         $display("FAIL wrong_fail: got fail=%b pass=%b led=%h want fail=1 pass=0 led=0",
                  bus.fail, bus.pass, bus.led_echo);
      end
      bus.btn = 4'd0;
      step(5);
      n_checks++;
      if (bus.fail !== 1'b1 || bus.pass !== 1'b0) begin
         n_fail++;
         $display("FAIL wrong_hold: got fail=%b pass=%b want fail=1 pass=0", bus.fail, bus.pass);
      end
      end_check();
      n_checks++;
      if (bus.fail !== 1'b0) begin
         n_fail++;
         $display("FAIL wrong_clear: got fail=%b want 0", bus.fail);
      end
      $display("test_wrong_button done");
   endtask

   // Bouncing never reaches a decision and does not restart the timeout.
   task automatic test_bounce();
      mem[0] = 2'd2;
      begin_check(4'd0);
      for (int c = 0; c < 5; c++) begin
         bus.btn = 4'b0100;
         step(2);
         bus.btn = 4'd0;
         step(2);
         n_checks++;
         if ({bus.addr, bus.pass, bus.fail, bus.led_echo} !== 16'd0) begin
            n_fail++;
            $display("FAIL bounce[%0d]: got addr=%0d pass=%b fail=%b led=%h want all 0",
                     c, bus.addr, bus.pass, bus.fail, bus.led_echo);
         end
      end
      step(TMO - 1 - 20);
      n_checks++;
      if (bus.fail !== 1'b0) begin
         n_fail++;
         $display("FAIL bounce_tmo_early: got fail=%b want 0", bus.fail);
      end
      step(1);
      n_checks++;
      if (bus.fail !== 1'b1) begin
         n_fail++;
         $display("FAIL bounce_tmo: got fail=%b want 1", bus.fail);
      end
      end_check();
      $display("test_bounce done");
   endtask

   task automatic test_multi_press();
      mem[0] = 2'd0;
      begin_check(4'd0);
      bus.btn = 4'b0011;
      step(10);
      n_checks++;
      if ({bus.addr, bus.pass, bus.fail, bus.led_echo} !== 16'd0) begin
         n_fail++;
         $display("FAIL multi_ignored: got addr=%0d pass=%b fail=%b led=%h want all 0",
                  bus.addr, bus.pass, bus.fail, bus.led_echo);
      end
      bus.btn = 4'd0;
      step(1);
      bus.btn = 4'b0001;
      step(DEB);
      n_checks++;
      if (bus.led_echo !== 10'h001) begin
         n_fail++;
         $display("FAIL multi_then_valid: got led=%h want 001", bus.led_echo);
      end
      bus.btn = 4'd0;
      step(1);
      n_checks++;
      if (bus.pass !== 1'b1) begin
         n_fail++;
         $display("FAIL multi_pass: got pass=%b want 1", bus.pass);
      end
      end_check();
      $display("test_multi_press done");
   endtask

   // Invalid patterns do not restart the timeout.
   task automatic test_timeout();
      begin_check(4'd3);
      bus.btn = 4'b1111;
      step(10);
      bus.btn = 4'b0110;
      step(10);
      bus.btn = 4'd0;
      step(TMO - 1 - 20);
      n_checks++;
      if (bus.fail !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_early: got fail=%b want 0", bus.fail);
      end
      step(1);
      n_checks++;
      if (bus.fail !== 1'b1 || bus.pass !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout: got fail=%b pass=%b want fail=1 pass=0", bus.fail, bus.pass);
      end
      end_check();
      $display("test_timeout done");
   endtask

   // An accepted press restarts the timeout window.
   task automatic test_timeout_after_accept();
      mem[0] = 2'd3;
      begin_check(4'd1);
      step(10);
      bus.btn = 4'b1000;
      step(DEB);
      bus.btn = 4'd0;
      step(1);
      n_checks++;
      if (bus.addr !== 4'd1) begin
         n_fail++;
         $display("FAIL tmo_acc_addr: got addr=%0d want 1", bus.addr);
      end
      step(TMO - 1);
      n_checks++;
      if (bus.fail !== 1'b0) begin
         n_fail++;
         $display("FAIL tmo_acc_early: got fail=%b want 0", bus.fail);
      end
      step(1);
      n_checks++;
      if (bus.fail !== 1'b1) begin
         n_fail++;
         $display("FAIL tmo_acc: got fail=%b want 1", bus.fail);
      end
      end_check();
      $display("test_timeout_after_accept done");
   endtask

   task automatic test_abort_and_level();
      mem[0] = 2'd3;
      begin_check(4'd0);
      bus.btn = 4'b1000;
      step(DEB);
      n_checks++;
      if (bus.led_echo !== 10'h008) begin
         n_fail++;
         $display("FAIL abort_echo: got led=%h want 008", bus.led_echo);
      end
      // Button still held: dropping check_en takes priority over release.
      bus.check_en = 1'b0;
      step(1);
      n_checks++;
      if ({bus.addr, bus.pass, bus.fail, bus.led_echo} !== 16'd0) begin
         n_fail++;
         $display("FAIL abort_clear: got addr=%0d pass=%b fail=%b led=%h want all 0",
                  bus.addr, bus.pass, bus.fail, bus.led_echo);
      end
      bus.btn = 4'd0;
      step(1);

      for (int lv = 10; lv < 16; lv++) begin
         begin_check(4'(lv));
         bus.btn = 4'b1000;
         step(DEB + 2);
         n_checks++;
         if ({bus.addr, bus.pass, bus.fail, bus.led_echo} !== 16'd0) begin
            n_fail++;
            $display("FAIL bad_level[%0d]: got addr=%0d pass=%b fail=%b led=%h want all 0",
                     lv, bus.addr, bus.pass, bus.fail, bus.led_echo);
         end
         end_check();
      end

      mem[0] = 2'd1;
      begin_check(4'd9);
      bus.btn = 4'b0010;
      step(DEB);
      n_checks++;
      if (bus.led_echo !== 10'h002) begin
         n_fail++;
         $display("FAIL level9_start: got led=%h want 002", bus.led_echo);
      end
      end_check();
      $display("test_abort_and_level done");
   endtask

   task automatic test_random_sequences();
      for (int s = 0; s < 25; s++) begin
         int         lvl;
         int         wrong_at;
         int         hold;
         logic [1:0] code;
         lvl      = $urandom_range(0, 9);
         wrong_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, lvl) : -1;
         for (int k = 0; k <= lvl; k++) mem[k] = 2'($urandom_range(0, 3));
         $display("seq %0d: level=%0d wrong_at=%0d", s, lvl, wrong_at);
         begin_check(4'(lvl));
         for (int i = 0; i <= lvl; i++) begin
            step($urandom_range(0, 4));
            if ($urandom_range(0, 1) == 1) begin
               bus.btn = onehot(2'($urandom_range(0, 3)));
               step($urandom_range(1, DEB - 1));
               bus.btn = 4'd0;
               step(1);
               n_checks++;
               if (bus.led_echo !== 10'd0 || bus.addr !== 4'(i) || bus.fail !== 1'b0) begin
                  n_fail++;
                  $display("FAIL rnd_bounce[%0d.%0d]: got led=%h addr=%0d fail=%b want led=0 addr=%0d fail=0",
                           s, i, bus.led_echo, bus.addr, bus.fail, i);
               end
            end
            code = (i == wrong_at) ? mem[i] + 2'($urandom_range(1, 3)) : mem[i];
            hold = $urandom_range(DEB, DEB + 3);
            bus.btn = onehot(code);
            step(DEB);
            if (i == wrong_at) begin
               n_checks++;
               if (bus.fail !== 1'b1 || bus.pass !== 1'b0 || bus.led_echo !== 10'd0) begin
                  n_fail++;
                  $display("FAIL rnd_wrong[%0d.%0d]: got fail=%b pass=%b led=%h want fail=1 pass=0 led=0",
                           s, i, bus.fail, bus.pass, bus.led_echo);
               end
               break;
            end
            n_checks++;
            if (bus.led_echo !== {6'd0, onehot(code)} || bus.fail !== 1'b0) begin
               n_fail++;
               $display("FAIL rnd_echo[%0d.%0d]: got led=%h fail=%b want led=%h fail=0",
                        s, i, bus.led_echo, bus.fail, {6'd0, onehot(code)});
            end
            step(hold - DEB);
            bus.btn = 4'd0;
            step(1);
            n_checks++;
            if (i == lvl) begin
               if (bus.pass !== 1'b1 || bus.fail !== 1'b0) begin
                  n_fail++;
                  $display("FAIL rnd_pass[%0d]: got pass=%b fail=%b want pass=1 fail=0",
                           s, bus.pass, bus.fail);
               end
            end else if (bus.addr !== 4'(i + 1) || bus.led_echo !== 10'd0) begin
               n_fail++;
               $display("FAIL rnd_addr[%0d.%0d]: got addr=%0d led=%h want addr=%0d led=0",
                        s, i, bus.addr, bus.led_echo, i + 1);
            end
         end
         end_check();
         n_checks++;
         if ({bus.addr, bus.pass, bus.fail, bus.led_echo} !== 16'd0) begin
            n_fail++;
            $display("FAIL rnd_end[%0d]: got addr=%0d pass=%b fail=%b led=%h want all 0",
                     s, bus.addr, bus.pass, bus.fail, bus.led_echo);
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 16; k++) mem[k] = 2'd0;
      test_reset();
      test_correct_sequence();
      test_wrong_button();
      test_bounce();
      test_multi_press();
      test_timeout();
      test_timeout_after_accept();
      test_abort_and_level();
      test_random_sequences();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/input_checker.md
INPUT_CHECKER -- requirements
Module: input_checker

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, is the number of clk cycles a button pattern must be stable to count as pressed (20 ms at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 250_000_000, is the maximum number of clk cycles allowed between accepted presses (5 s at 50 MHz).
REQ-003 clk  input  1  system clock, 50 MHz; the block has one clock and all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 check_en  input  1  from fsm; high while the player is entering the sequence.
REQ-006 level  input  4  from fsm; sequence length is level+1; valid range 0..9.
REQ-007 btn  input  4  player buttons, active-high, already synchronised to clk.
REQ-008 expected  input  2  from simple_memory; the LED code stored at addr, valid in the same cycle (asynchronous read).
REQ-009 addr  output  4  read address to simple_memory; index of the press being checked.
REQ-010 pass  output  1  to fsm; whole sequence entered correctly.
REQ-011 fail  output  1  to fsm; wrong button or timeout.
REQ-012 led_echo  output  10  to top level; one-hot echo of the accepted button, bits 9:4 always 0.

Function
REQ-013 Button encoding: btn=4'b0001->2'd0, 4'b0010->2'd1, 4'b0100->2'd2, 4'b1000->2'd3; any other non-zero pattern is invalid.
REQ-014 States: IDLE, WAIT_PRESS, DEBOUNCE, WAIT_RELEASE, PASS, FAIL.
REQ-015 IDLE: addr=0, pass=0, fail=0, led_echo=0; move to WAIT_PRESS when check_en=1 and level<=9; stay in IDLE if level>=10.
REQ-016 WAIT_PRESS: the timeout counter increments every cycle.
REQ-017 WAIT_PRESS exit on timeout: when the timeout counter reaches TIMEOUT_CYCLES-1, go to FAIL.
REQ-018 WAIT_PRESS exit on press: when btn is a valid one-hot pattern, latch the pattern, clear the debounce counter, and go to DEBOUNCE.
REQ-019 WAIT_PRESS ignores invalid patterns: zero or multi-bit btn keeps the block in WAIT_PRESS and does not reset the timeout counter.
REQ-020 DEBOUNCE: if btn differs from the latched pattern in any cycle, return to WAIT_PRESS; the timeout counter keeps counting and is not cleared.
REQ-021 DEBOUNCE complete: when btn has equalled the latched pattern for DEBOUNCE_CYCLES consecutive cycles, compare the encoded pattern with expected.
REQ-022 On mismatch, go to FAIL.
REQ-023 On match, go to WAIT_RELEASE and clear the timeout counter.
REQ-024 WAIT_RELEASE: led_echo={6'd0, latched pattern}; the state is held while btn is non-zero.
REQ-025 Leaving WAIT_RELEASE: on the first cycle with btn=0, led_echo goes to 0 at the next edge; if addr==level go to PASS, otherwise addr<=addr+1 and go to WAIT_PRESS.
REQ-026 PASS: pass=1 is held until check_en=0.
REQ-027 FAIL: fail=1 is held until check_en=0.
REQ-028 pass and fail are never high in the same cycle.
REQ-029 In any state, check_en=0 forces IDLE at the next edge and clears all outputs and counters; check_en has priority over press, release and timeout events in the same cycle.
REQ-030 Counter widths: counters are sized for their parameter and saturate, never wrap.
REQ-031 addr range: addr never exceeds level, so it never wraps.

Reset
REQ-032 reset=1 at a rising edge forces IDLE and sets addr=0, pass=0, fail=0, led_echo=0, and clears both counters, regardless of state or check_en.
REQ-033 Reset mid-sequence discards all progress; after reset deasserts the block restarts from addr=0 on the next check_en=1.

Verification (benches use DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=50)
REQ-034 Correct sequence: level=2, memory {1,3,0}, check_en=1; press btn=0010 then 1000 then 0001, each held 6 cycles then released -> addr steps 0,1,2; pass=1 after the third release; fail stays 0.
REQ-035 Wrong button: level=1, expected=2 at addr 0; press btn=0001 for 4 cycles -> fail=1 one edge after debounce completes; led_echo stays 0.
REQ-036 Bounce rejection: btn toggles 0100/0000 every 2 cycles for 20 cycles -> remains in WAIT_PRESS/DEBOUNCE, addr=0, no pass or fail.
REQ-037 Timeout: check_en=1 with no press for 50 cycles -> fail=1 at cycle 50.
REQ-038 Multi-press: btn=0011 held 10 cycles -> ignored, addr=0, no fail.
REQ-039 Abort and invalid level: check_en drops during WAIT_RELEASE -> all outputs 0 at the next edge; with level=12 and check_en=1, the block stays IDLE with pass=fail=0.
